// File: rtl/ahb_cache_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_cache_arbiter
//
// Purpose:
//   Shares one external AHB-Lite master port between the instruction cache
//   (master I) and the data cache (master D). Ownership is granted per burst
//   and held until the owner drops its sel. D has fixed priority. A
//   starvation counter guarantees that I makes forward progress: after
//   STARVE_LIMIT consecutive D grants while I was waiting, I is granted next.
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   im_* / dm_*          request side of master I / master D (address phase,
//                        write data, sel held for the whole burst)
//   im_hrdata/dm_hrdata  fabric read data, broadcast to both masters
//   im_/dm_hready_out    fabric ready, gated by that master's grant
//   im_/dm_hresp         fabric response, gated by that master's grant
//   AHB_*                request side towards the system fabric
//   AHB_hready_in        fabric ready looped back as the ready-in
//   AHB_hrdata/_hready_out/_hresp  fabric response side
//   grant                one-hot owner, bit0 = I, bit1 = D, 00 when idle
// ---------------------------------------------------------------------------
module ahb_cache_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        nrst,

  input  logic [31:0] im_haddr,
  input  logic [2:0]  im_hburst,
  input  logic [3:0]  im_hprot,
  input  logic [2:0]  im_hsize,
  input  logic [1:0]  im_htrans,
  input  logic [31:0] im_hwdata,
  input  logic        im_hwrite,
  input  logic        im_sel,
  output logic [31:0] im_hrdata,
  output logic        im_hready_out,
  output logic        im_hresp,

  input  logic [31:0] dm_haddr,
  input  logic [2:0]  dm_hburst,
  input  logic [3:0]  dm_hprot,
  input  logic [2:0]  dm_hsize,
  input  logic [1:0]  dm_htrans,
  input  logic [31:0] dm_hwdata,
  input  logic        dm_hwrite,
  input  logic        dm_sel,
  output logic [31:0] dm_hrdata,
  output logic        dm_hready_out,
  output logic        dm_hresp,

  output logic [31:0] AHB_haddr,
  output logic [2:0]  AHB_hburst,
  output logic [3:0]  AHB_hprot,
  output logic [2:0]  AHB_hsize,
  output logic [1:0]  AHB_htrans,
  output logic [31:0] AHB_hwdata,
  output logic        AHB_hwrite,
  output logic        AHB_sel,
  output logic        AHB_hready_in,
  input  logic [31:0] AHB_hrdata,
  input  logic        AHB_hready_out,
  input  logic        AHB_hresp,

  output logic [1:0]  grant
);

  // State encoding doubles as the one-hot grant, so grant is registered
  // for free and can never read 11.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_OWN_I = 2'b01;
  localparam logic [1:0] ST_OWN_D = 2'b10;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Idle-bus defaults presented to the fabric when nobody owns it.
  localparam logic [2:0] IDLE_HBURST = 3'b000;
  localparam logic [3:0] IDLE_HPROT  = 4'b0011;
  localparam logic [2:0] IDLE_HSIZE  = 3'b010;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  logic [1:0] state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       i_forced;

  // I has waited through the full allowance of D grants.
  assign i_forced = im_sel && (starve_cnt_q == LIMIT);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (dm_sel && !i_forced) begin
          state_d = ST_OWN_D;
          if (im_sel) begin
            if (starve_cnt_q < LIMIT) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
          end else begin
            starve_cnt_d = 4'd0;
          end
        end else if (im_sel) begin
          state_d      = ST_OWN_I;
          starve_cnt_d = 4'd0;
        end
      end
      // Dropping sel always passes through IDLE, which gives the fabric a
      // dead cycle between owners.
      ST_OWN_I: begin
        if (!im_sel) begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN_D: begin
        if (!dm_sel) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign grant = state_q;

  // Request mux: the owner's address phase and write data pass straight
  // through. Because the state only leaves OWN after sel falls, the last
  // data beat's hwdata is still routed from the owner.
  always_comb begin
    AHB_haddr  = 32'd0;
    AHB_hburst = IDLE_HBURST;
    AHB_hprot  = IDLE_HPROT;
    AHB_hsize  = IDLE_HSIZE;
    AHB_htrans = HTRANS_IDLE;
    AHB_hwdata = 32'd0;
    AHB_hwrite = 1'b0;
    AHB_sel    = 1'b0;
    case (state_q)
      ST_OWN_I: begin
        AHB_haddr  = im_haddr;
        AHB_hburst = im_hburst;
        AHB_hprot  = im_hprot;
        AHB_hsize  = im_hsize;
        AHB_htrans = im_htrans;
        AHB_hwdata = im_hwdata;
        AHB_hwrite = im_hwrite;
        AHB_sel    = im_sel;
      end
      ST_OWN_D: begin
        AHB_haddr  = dm_haddr;
        AHB_hburst = dm_hburst;
        AHB_hprot  = dm_hprot;
        AHB_hsize  = dm_hsize;
        AHB_htrans = dm_htrans;
        AHB_hwdata = dm_hwdata;
        AHB_hwrite = dm_hwrite;
        AHB_sel    = dm_sel;
      end
      default: begin
      end
    endcase
  end

  // Response side: a non-owner sees hready low and so holds its address
  // phase until it is granted.
  assign AHB_hready_in = AHB_hready_out;
  assign im_hrdata     = AHB_hrdata;
  assign dm_hrdata     = AHB_hrdata;
  assign im_hready_out = AHB_hready_out & grant[0];
  assign dm_hready_out = AHB_hready_out & grant[1];
  assign im_hresp      = AHB_hresp & grant[0];
  assign dm_hresp      = AHB_hresp & grant[1];

endmodule
